fwrisc_dbg_trace_buf: RTL and testbench
=======================================

# fwrisc_dbg_trace_buf

Retirement trace capture for the fwrisc core. It gathers each instruction's register-writeback and memory side-effects and packs them with pc/instr into one record at retirement. Records go into a parametrised FIFO and drain over a valid/ready stream to a debug BFM, trace dumper or checker. Overflow is counted, not stalled. It sits beside the core on the same debug tap signals as the existing debug BFM wrapper.

## Interface
- XLEN, 32: data/address width of pc, instr, rd_wdata, maddr, mdata.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- CNT_W, 16: width of retire-order counter and drop counter.
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture enable; 0 suppresses pushes (accumulation still clears on ivalid).
- pc  in  XLEN  pc of the instruction in execute.
- instr  in  32  instruction word.
- ivalid  in  1  execute/retire strobe; writeback may coincide.
- trap  in  1  instruction trapped; sampled with ivalid.
- rd_waddr  in  5; rd_wdata  in  XLEN; rd_write  in  1  register writeback.
- maddr  in  XLEN; mdata  in  XLEN; mstrb  in  4; mwrite  in  1; mvalid  in  1  memory access.
- t_valid  out  1  record available.
- t_ready  in  1  consumer accepts record.
- t_order, t_pc, t_instr, t_trap, t_rd_addr, t_rd_wdata, t_mem_addr, t_mem_rmask, t_mem_wmask, t_mem_data  out  (CNT_W, XLEN, 32, 1, 5, XLEN, XLEN, 4, 4, XLEN)  head record fields.
- overflow  out  1  sticky: a record was dropped since reset.
- drop_count  out  CNT_W  dropped records, saturating at all-ones.

## Operation
- Accumulator regs (acc_rd_addr/wdata, acc_mem_addr/data/rmask/wmask) collect side-effects between retirements.
- rd_write: acc_rd_* <= rd_waddr/rd_wdata; rd_waddr==0 is recorded as addr 0, wdata 0.
- mvalid & mwrite: acc_mem_addr<=maddr, acc_mem_wmask<=mstrb, acc_mem_data<=mdata, acc_mem_rmask<=0.
- mvalid & !mwrite: acc_mem_addr<=maddr, acc_mem_rmask<=mstrb (actual strobe, not 4'hf), acc_mem_data<=mdata, acc_mem_wmask<=0.
- Multiple accesses/writes before one retire: last wins.
- On ivalid: record = {order, pc, instr, trap, merged side-effects}. Merge: any rd_write/mvalid in the same cycle overrides the accumulator (same-cycle writeback belongs to this instruction). Accumulator then clears to 0; order increments (wraps modulo 2^CNT_W) whether or not pushed.
- Push when ivalid & enable. If FIFO full and no pop this cycle: drop, overflow<=1, drop_count++ (saturate).
- Full with simultaneous pop: push accepted, no drop.
- Pop when t_valid & t_ready. Outputs hold stable while t_valid & !t_ready.

## Timing
- Reset: all outputs 0, FIFO empty, order 0, accumulator 0, overflow 0, drop_count 0. Reset mid-stream discards FIFO contents without output.
- Latency: record pushed at ivalid edge N is on t_* with t_valid=1 after edge N (visible cycle N+1) if FIFO was empty.
- Throughput: one push and one pop per cycle; back-to-back ivalid supported.
- Empty: t_valid=0; t_* show last/zero contents, don't-care.
- Pointers log2(DEPTH)+1 bits; full when MSBs differ and LSBs equal.

## Structure
- Package fwrisc_dbg_pkg: record field widths, TRACE_W (total packed width) as function of XLEN/CNT_W, field offset localparams, pack/unpack helpers.
- Sub-module fwrisc_dbg_trace_fifo: generic sync FIFO (WIDTH, DEPTH), push/pop/full/empty, registered storage. Top holds accumulator, merge, counters.

## Test plan
- Single ADD retire, rd_write x5=0x1234 same cycle as ivalid, pc=0x80 -> one record: order 0, rd_addr 5, rd_wdata 0x1234, masks 0, t_valid next cycle.
- Load: mvalid read maddr=0x100, mstrb=4'b0011, mdata=0xBEEF two cycles before ivalid -> rmask 0011, wmask 0, mem_data 0xBEEF; following retire has all mem fields 0.
- Store then retire, then retire with no side-effects -> records 0/1 with wmask/data set then all-zero side-effects; orders 0,1.
- t_ready=0, DEPTH+3 retires -> DEPTH records held (orders 0..DEPTH-1), drop_count=3, overflow=1; drain yields orders in sequence, next retire carries order DEPTH+3.
- Full FIFO, ivalid and t_ready same cycle -> no drop, count stays DEPTH.
- Reset asserted with 3 records queued -> t_valid=0 next cycle, order/drop_count/overflow 0; enable=0 retires produce no records but advance order.

Source files
------------

// File: rtl/fwrisc_dbg_pkg.sv
// Shared definitions for the fwrisc retirement trace buffer.
// The record layout and the packing helpers live here so that the buffer,
// its FIFO and any consumer agree on one bit layout.
package fwrisc_dbg_pkg;

    localparam int XLEN_MAX  = 64;
    localparam int CNT_W_MAX = 32;
    localparam int INSTR_W   = 32;
    localparam int RADDR_W   = 5;
    localparam int MASK_W    = 4;
    localparam int FIXED_W   = INSTR_W + 1 + RADDR_W + 2 * MASK_W;
    localparam int TRACE_W_MAX = CNT_W_MAX + 4 * XLEN_MAX + FIXED_W;

    // Record layout, LSB first: mem_data, wmask, rmask, mem_addr, rd_wdata,
    // rd_addr, trap, instr, pc, order.
    localparam int OFF_MEM_DATA = 0;

    typedef logic [TRACE_W_MAX-1:0] trace_vec_t;

    // One retirement record at the widest supported field widths;
    // narrower instances leave the upper bits of each field at zero.
    typedef struct packed {
        logic [CNT_W_MAX-1:0] order;
        logic [XLEN_MAX-1:0]  pc;
        logic [INSTR_W-1:0]   instr;
        logic                 trap;
        logic [RADDR_W-1:0]   rd_addr;
        logic [XLEN_MAX-1:0]  rd_wdata;
        logic [XLEN_MAX-1:0]  mem_addr;
        logic [MASK_W-1:0]    mem_rmask;
        logic [MASK_W-1:0]    mem_wmask;
        logic [XLEN_MAX-1:0]  mem_data;
    } trace_rec_t;

    function automatic int trace_w(int xlen, int cnt_w);
        return cnt_w + 4 * xlen + FIXED_W;
    endfunction

    function automatic int off_wmask(int xlen);    return xlen;           endfunction
    function automatic int off_rmask(int xlen);    return xlen + 4;       endfunction
    function automatic int off_mem_addr(int xlen); return xlen + 8;       endfunction
    function automatic int off_rd_wdata(int xlen); return 2 * xlen + 8;   endfunction
    function automatic int off_rd_addr(int xlen);  return 3 * xlen + 8;   endfunction
    function automatic int off_trap(int xlen);     return 3 * xlen + 13;  endfunction
    function automatic int off_instr(int xlen);    return 3 * xlen + 14;  endfunction
    function automatic int off_pc(int xlen);       return 3 * xlen + 46;  endfunction
    function automatic int off_order(int xlen);    return 4 * xlen + 46;  endfunction

    function automatic trace_vec_t field_mask(int w);
        return (trace_vec_t'(1) << w) - trace_vec_t'(1);
    endfunction

    function automatic trace_vec_t put_field(trace_vec_t v, trace_vec_t f, int off, int w);
        return v | ((f & field_mask(w)) << off);
    endfunction

    function automatic trace_vec_t get_field(trace_vec_t v, int off, int w);
        return (v >> off) & field_mask(w);
    endfunction

    // Pack a record into the dense layout for the given XLEN/CNT_W.
    function automatic trace_vec_t pack_rec(trace_rec_t r, int xlen, int cnt_w);
        trace_vec_t v;
        v = '0;
        v = put_field(v, trace_vec_t'(r.mem_data),  OFF_MEM_DATA,       xlen);
        v = put_field(v, trace_vec_t'(r.mem_wmask), off_wmask(xlen),    MASK_W);
        v = put_field(v, trace_vec_t'(r.mem_rmask), off_rmask(xlen),    MASK_W);
        v = put_field(v, trace_vec_t'(r.mem_addr),  off_mem_addr(xlen), xlen);
        v = put_field(v, trace_vec_t'(r.rd_wdata),  off_rd_wdata(xlen), xlen);
        v = put_field(v, trace_vec_t'(r.rd_addr),   off_rd_addr(xlen),  RADDR_W);
        v = put_field(v, trace_vec_t'(r.trap),      off_trap(xlen),     1);
        v = put_field(v, trace_vec_t'(r.instr),     off_instr(xlen),    INSTR_W);
        v = put_field(v, trace_vec_t'(r.pc),        off_pc(xlen),       xlen);
        v = put_field(v, trace_vec_t'(r.order),     off_order(xlen),    cnt_w);
        return v;
    endfunction

endpackage

// File: rtl/fwrisc_dbg_trace_buf_if.sv
// Trace record stream: producer drives the head record and t_valid,
// consumer answers with t_ready.
interface fwrisc_dbg_trace_buf_if
    import fwrisc_dbg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic               t_valid;
    logic               t_ready;
    logic [CNT_W-1:0]   t_order;
    logic [XLEN-1:0]    t_pc;
    logic [INSTR_W-1:0] t_instr;
    logic               t_trap;
    logic [RADDR_W-1:0] t_rd_addr;
    logic [XLEN-1:0]    t_rd_wdata;
    logic [XLEN-1:0]    t_mem_addr;
    logic [MASK_W-1:0]  t_mem_rmask;
    logic [MASK_W-1:0]  t_mem_wmask;
    logic [XLEN-1:0]    t_mem_data;

    modport master (
        output t_valid, t_order, t_pc, t_instr, t_trap, t_rd_addr, t_rd_wdata,
               t_mem_addr, t_mem_rmask, t_mem_wmask, t_mem_data,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_order, t_pc, t_instr, t_trap, t_rd_addr, t_rd_wdata,
               t_mem_addr, t_mem_rmask, t_mem_wmask, t_mem_data,
        output t_ready
    );
endinterface

// File: rtl/fwrisc_dbg_trace_fifo.sv
// Generic synchronous FIFO with registered storage and a combinational
// head read. Pointers carry one extra wrap bit to tell full from empty.
module fwrisc_dbg_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A push into a full FIFO is still legal when the head leaves this cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clock) begin
        // NOTE: storage is deliberately not reset; emptiness comes from the pointers alone.
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/fwrisc_dbg_trace_buf.sv
// Retirement trace buffer: accumulates writeback and memory side-effects
// between retirements, packs them into a record on ivalid and queues it
// for a valid/ready consumer. Overflow drops records and counts them.
module fwrisc_dbg_trace_buf
    import fwrisc_dbg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [XLEN-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               ivalid,
    input  logic               trap,
    input  logic [RADDR_W-1:0] rd_waddr,
    input  logic [XLEN-1:0]    rd_wdata,
    input  logic               rd_write,
    input  logic [XLEN-1:0]    maddr,
    input  logic [XLEN-1:0]    mdata,
    input  logic [MASK_W-1:0]  mstrb,
    input  logic               mwrite,
    input  logic               mvalid,
    fwrisc_dbg_trace_buf_if.master tif,
    output logic               overflow,
    output logic [CNT_W-1:0]   drop_count
);
    localparam int TRACE_W = trace_w(XLEN, CNT_W);

    logic [RADDR_W-1:0] acc_rd_addr;
    logic [XLEN-1:0]    acc_rd_wdata;
    logic [XLEN-1:0]    acc_mem_addr;
    logic [XLEN-1:0]    acc_mem_data;
    logic [MASK_W-1:0]  acc_mem_rmask;
    logic [MASK_W-1:0]  acc_mem_wmask;
    logic [CNT_W-1:0]   retire_order;

    logic [XLEN-1:0]    rd_wdata_eff;
    trace_rec_t         rec;
    logic [TRACE_W-1:0] fifo_wdata;
    logic [TRACE_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_req;
    logic               pop;
    logic               drop;

    // Writes to x0 are architecturally invisible, so they trace as zero data.
    assign rd_wdata_eff = (rd_waddr == '0) ? '0 : rd_wdata;

    assign push_req = ivalid && enable;
    assign pop      = !fifo_empty && tif.t_ready;
    assign drop     = push_req && fifo_full && !pop;

    // Collect side-effects between retirements; last write wins, retire clears.
    always_ff @(posedge clock) begin
        if (reset || ivalid) begin
            acc_rd_addr   <= '0;
            acc_rd_wdata  <= '0;
            acc_mem_addr  <= '0;
            acc_mem_data  <= '0;
            acc_mem_rmask <= '0;
            acc_mem_wmask <= '0;
        end else begin
            if (rd_write) begin
                acc_rd_addr  <= rd_waddr;
                acc_rd_wdata <= rd_wdata_eff;
            end
            if (mvalid) begin
                acc_mem_addr  <= maddr;
                acc_mem_data  <= mdata;
                acc_mem_rmask <= mwrite ? '0 : mstrb;
                acc_mem_wmask <= mwrite ? mstrb : '0;
            end
        end
    end

    // Build the retiring record; same-cycle side-effects override the accumulator.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rec          = '0;
        rec.order    = CNT_W_MAX'(retire_order);
        rec.pc       = XLEN_MAX'(pc);
        rec.instr    = instr;
        rec.trap     = trap;
        rec.rd_addr  = acc_rd_addr;
        rec.rd_wdata = XLEN_MAX'(acc_rd_wdata);
        rec.mem_addr = XLEN_MAX'(acc_mem_addr);
        rec.mem_data = XLEN_MAX'(acc_mem_data);
        rec.mem_rmask = acc_mem_rmask;
        rec.mem_wmask = acc_mem_wmask;
        if (rd_write) begin
            rec.rd_addr  = rd_waddr;
            rec.rd_wdata = XLEN_MAX'(rd_wdata_eff);
        end
        if (mvalid) begin
            rec.mem_addr  = XLEN_MAX'(maddr);
            rec.mem_data  = XLEN_MAX'(mdata);
            rec.mem_rmask = mwrite ? '0 : mstrb;
            rec.mem_wmask = mwrite ? mstrb : '0;
        end
    end

    assign fifo_wdata = TRACE_W'(pack_rec(rec, XLEN, CNT_W));

    fwrisc_dbg_trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Retire order advances on every retirement; drops are sticky and saturate.
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_order <= '0;
            overflow     <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (ivalid) retire_order <= retire_order + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end

    // Unpack the head record; fields read as zero while the FIFO is empty.
    always_comb begin
        tif.t_valid     = !fifo_empty;
        tif.t_order     = '0;
        tif.t_pc        = '0;
        tif.t_instr     = '0;
        tif.t_trap      = 1'b0;
        tif.t_rd_addr   = '0;
        tif.t_rd_wdata  = '0;
        tif.t_mem_addr  = '0;
        tif.t_mem_rmask = '0;
        tif.t_mem_wmask = '0;
        tif.t_mem_data  = '0;
        if (!fifo_empty) begin
            tif.t_order     = CNT_W'(get_field(trace_vec_t'(fifo_rdata), off_order(XLEN), CNT_W));
            tif.t_pc        = XLEN'(get_field(trace_vec_t'(fifo_rdata), off_pc(XLEN), XLEN));
            tif.t_instr     = INSTR_W'(get_field(trace_vec_t'(fifo_rdata), off_instr(XLEN), INSTR_W));
            tif.t_trap      = 1'(get_field(trace_vec_t'(fifo_rdata), off_trap(XLEN), 1));
            tif.t_rd_addr   = RADDR_W'(get_field(trace_vec_t'(fifo_rdata), off_rd_addr(XLEN), RADDR_W));
            tif.t_rd_wdata  = XLEN'(get_field(trace_vec_t'(fifo_rdata), off_rd_wdata(XLEN), XLEN));
            tif.t_mem_addr  = XLEN'(get_field(trace_vec_t'(fifo_rdata), off_mem_addr(XLEN), XLEN));
            tif.t_mem_rmask = MASK_W'(get_field(trace_vec_t'(fifo_rdata), off_rmask(XLEN), MASK_W));
            tif.t_mem_wmask = MASK_W'(get_field(trace_vec_t'(fifo_rdata), off_wmask(XLEN), MASK_W));
            tif.t_mem_data  = XLEN'(get_field(trace_vec_t'(fifo_rdata), OFF_MEM_DATA, XLEN));
        end
    end
endmodule

// File: tb/tb_fwrisc_dbg_trace_buf.sv
// Self-checking bench for fwrisc_dbg_trace_buf: a directed vector table,
// hand-written overflow/reset sequences and a randomized run against a
// queue-based reference model.
module tb_fwrisc_dbg_trace_buf;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ivalid;
    logic        trap;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_write;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [3:0]  mstrb;
    logic        mwrite;
    logic        mvalid;
    logic        overflow;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    fwrisc_dbg_trace_buf_if #(.XLEN(XLEN), .CNT_W(CNT_W)) tif ();

    fwrisc_dbg_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .pc         (pc),
        .instr      (instr),
        .ivalid     (ivalid),
        .trap       (trap),
        .rd_waddr   (rd_waddr),
        .rd_wdata   (rd_wdata),
        .rd_write   (rd_write),
        .maddr      (maddr),
        .mdata      (mdata),
        .mstrb      (mstrb),
        .mwrite     (mwrite),
        .mvalid     (mvalid),
        .tif        (tif),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ivalid = 0; trap = 0; rd_write = 0; rd_waddr = 0; rd_wdata = 0;
        mvalid = 0; mwrite = 0; maddr = 0; mdata = 0; mstrb = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle(); tick(); tick(); reset = 0;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] order;
        logic [31:0] pc, instr;
        logic        trap;
        logic [4:0]  rd;
        logic [31:0] rdw, maddr;
        logic [3:0]  rmask, wmask;
        logic [31:0] mdata;
    } rec_t;

    rec_t        q[$];
    rec_t        acc;
    logic [15:0] m_order;
    int          m_drops;
    bit          m_ovf;

    task automatic model_clear();
        q.delete();
        acc = '{default: 0};
        m_order = 0; m_drops = 0; m_ovf = 0;
    endtask

    // One clock edge of the model, evaluated from the inputs about to be sampled.
    task automatic model_step();
        rec_t r;
        if (reset) begin model_clear(); return; end
        if (q.size() > 0 && tif.t_ready) void'(q.pop_front());
        if (ivalid) begin
            r = acc;
            r.order = m_order; r.pc = pc; r.instr = instr; r.trap = trap;
            if (rd_write) begin
                r.rd = rd_waddr;
                r.rdw = (rd_waddr == 0) ? 32'h0 : rd_wdata;
            end
            if (mvalid) begin
                r.maddr = maddr; r.mdata = mdata;
                r.rmask = mwrite ? 4'h0 : mstrb;
                r.wmask = mwrite ? mstrb : 4'h0;
            end
            if (enable) begin
                if (q.size() < DEPTH) q.push_back(r);
                else begin m_ovf = 1; m_drops++; end
            end
            m_order++;
            acc = '{default: 0};
        end else begin
            if (rd_write) begin
                acc.rd = rd_waddr;
                acc.rdw = (rd_waddr == 0) ? 32'h0 : rd_wdata;
            end
            if (mvalid) begin
                acc.maddr = maddr; acc.mdata = mdata;
                acc.rmask = mwrite ? 4'h0 : mstrb;
                acc.wmask = mwrite ? mstrb : 4'h0;
            end
        end
    endtask

    task automatic compare_model();
        check("rnd_valid", tif.t_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("rnd_order", tif.t_order, q[0].order);
            check("rnd_pc", tif.t_pc, q[0].pc);
            check("rnd_instr", tif.t_instr, q[0].instr);
            check("rnd_trap", tif.t_trap, q[0].trap);
            check("rnd_rd_addr", tif.t_rd_addr, q[0].rd);
            check("rnd_rd_wdata", tif.t_rd_wdata, q[0].rdw);
            check("rnd_mem_addr", tif.t_mem_addr, q[0].maddr);
            check("rnd_rmask", tif.t_mem_rmask, q[0].rmask);
            check("rnd_wmask", tif.t_mem_wmask, q[0].wmask);
            check("rnd_mem_data", tif.t_mem_data, q[0].mdata);
        end
        check("rnd_overflow", overflow, m_ovf);
        check("rnd_drop_count", drop_count, (m_drops > 65535) ? 65535 : m_drops);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ivalid, trap, rd_write;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mvalid, mwrite;
        logic [31:0] maddr;
        logic [3:0]  mstrb;
        logic [31:0] mdata, pc;
        logic        e_valid;
        logic [15:0] e_order;
        logic [31:0] e_pc;
        logic        e_trap;
        logic [4:0]  e_rd;
        logic [31:0] e_rdw, e_maddr;
        logic [3:0]  e_rmask, e_wmask;
        logic [31:0] e_mdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        logic [15:0] last;

        // ivalid trap rdw waddr wdata | mvalid mwrite maddr mstrb mdata pc | expected head
        vecs[0]  = '{1'b1,1'b0,1'b1,5'd5,32'h1234, 1'b0,1'b0,32'h0,4'h0,32'h0, 32'h80,
                     1'b1,16'd0,32'h80,1'b0,5'd5,32'h1234,32'h0,4'h0,4'h0,32'h0};
        vecs[1]  = '{1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 32'h0,
                     1'b0,16'd0,32'h0,1'b0,5'd0,32'h0,32'h0,4'h0,4'h0,32'h0};
        vecs[2]  = '{1'b0,1'b0,1'b0,5'd0,32'h0, 1'b1,1'b0,32'h100,4'b0011,32'hBEEF, 32'h0,
                     1'b0,16'd0,32'h0,1'b0,5'd0,32'h0,32'h0,4'h0,4'h0,32'h0};
        vecs[3]  = vecs[1];
        vecs[4]  = '{1'b1,1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 32'h84,
                     1'b1,16'd1,32'h84,1'b0,5'd0,32'h0,32'h100,4'b0011,4'h0,32'hBEEF};
        vecs[5]  = '{1'b1,1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 32'h88,
                     1'b1,16'd2,32'h88,1'b0,5'd0,32'h0,32'h0,4'h0,4'h0,32'h0};
        vecs[6]  = '{1'b1,1'b0,1'b0,5'd0,32'h0, 1'b1,1'b1,32'h200,4'hf,32'hCAFEF00D, 32'h8c,
                     1'b1,16'd3,32'h8c,1'b0,5'd0,32'h0,32'h200,4'h0,4'hf,32'hCAFEF00D};
        vecs[7]  = '{1'b1,1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 32'h90,
                     1'b1,16'd4,32'h90,1'b0,5'd0,32'h0,32'h0,4'h0,4'h0,32'h0};
        vecs[8]  = '{1'b0,1'b0,1'b1,5'd0,32'hDEAD, 1'b0,1'b0,32'h0,4'h0,32'h0, 32'h0,
                     1'b0,16'd0,32'h0,1'b0,5'd0,32'h0,32'h0,4'h0,4'h0,32'h0};
        vecs[9]  = '{1'b1,1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 32'h94,
                     1'b1,16'd5,32'h94,1'b0,5'd0,32'h0,32'h0,4'h0,4'h0,32'h0};
        vecs[10] = '{1'b0,1'b0,1'b1,5'd7,32'h11, 1'b1,1'b0,32'h300,4'h1,32'h55, 32'h0,
                     1'b0,16'd0,32'h0,1'b0,5'd0,32'h0,32'h0,4'h0,4'h0,32'h0};
        vecs[11] = '{1'b1,1'b1,1'b1,5'd8,32'h22, 1'b1,1'b1,32'h304,4'h2,32'h66, 32'h98,
                     1'b1,16'd6,32'h98,1'b1,5'd8,32'h22,32'h304,4'h0,4'h2,32'h66};

        reset = 1; enable = 1; pc = 0; instr = 0; tif.t_ready = 1; idle();
        tick();
        check("reset_valid", tif.t_valid, 0);
        check("reset_order", tif.t_order, 0);
        check("reset_overflow", overflow, 0);
        check("reset_drop_count", drop_count, 0);
        tick();
        reset = 0;

        // ---- table ----
        for (int i = 0; i < 12; i++) begin
            ivalid = vecs[i].ivalid; trap = vecs[i].trap; rd_write = vecs[i].rd_write;
            rd_waddr = vecs[i].waddr; rd_wdata = vecs[i].wdata;
            mvalid = vecs[i].mvalid; mwrite = vecs[i].mwrite; maddr = vecs[i].maddr;
            mstrb = vecs[i].mstrb; mdata = vecs[i].mdata; pc = vecs[i].pc;
            instr = vecs[i].pc ^ 32'h0000_0033;
            tick();
            check($sformatf("vec%0d_valid", i), tif.t_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_order", i), tif.t_order, vecs[i].e_order);
                check($sformatf("vec%0d_pc", i), tif.t_pc, vecs[i].e_pc);
                check($sformatf("vec%0d_trap", i), tif.t_trap, vecs[i].e_trap);
                check($sformatf("vec%0d_rd_addr", i), tif.t_rd_addr, vecs[i].e_rd);
                check($sformatf("vec%0d_rd_wdata", i), tif.t_rd_wdata, vecs[i].e_rdw);
                check($sformatf("vec%0d_mem_addr", i), tif.t_mem_addr, vecs[i].e_maddr);
                check($sformatf("vec%0d_rmask", i), tif.t_mem_rmask, vecs[i].e_rmask);
                check($sformatf("vec%0d_wmask", i), tif.t_mem_wmask, vecs[i].e_wmask);
                check($sformatf("vec%0d_mem_data", i), tif.t_mem_data, vecs[i].e_mdata);
            end
        end
        idle();

        // ---- overflow: DEPTH+3 retires with consumer stalled ----
        do_reset();
        tif.t_ready = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            ivalid = 1; pc = 32'(i * 4); tick();
        end
        ivalid = 0;
        check("ovf_drop_count", drop_count, 3);
        check("ovf_overflow", overflow, 1);
        check("ovf_valid", tif.t_valid, 1);
        tick();
        check("ovf_hold_order", tif.t_order, 0);
        tif.t_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovf_drain_valid%0d", i), tif.t_valid, 1);
            check($sformatf("ovf_drain_order%0d", i), tif.t_order, i);
            tick();
        end
        check("ovf_drained", tif.t_valid, 0);
        tif.t_ready = 0;
        ivalid = 1; tick(); ivalid = 0;
        check("ovf_next_order", tif.t_order, DEPTH + 3);

        // ---- full FIFO with simultaneous push and pop ----
        do_reset();
        tif.t_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ivalid = 1; tick();
        end
        ivalid = 1; tif.t_ready = 1; tick(); ivalid = 0;
        check("full_pp_drop_count", drop_count, 0);
        check("full_pp_overflow", overflow, 0);
        check("full_pp_head", tif.t_order, 1);
        n = 0; last = 0;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            if (!tif.t_valid) break;
            last = tif.t_order; n++;
            tick();
        end
        check("full_pp_count", n, DEPTH);
        check("full_pp_last_order", last, DEPTH);

        // ---- reset mid-stream, then enable=0 retires ----
        do_reset();
        tif.t_ready = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            ivalid = 1; pc = 32'h400 + 32'(i); tick();
        end
        ivalid = 0;
        check("rst_pre_drop", drop_count, 1);
        reset = 1; tick(); reset = 0;
        check("rst_valid", tif.t_valid, 0);
        check("rst_pc", tif.t_pc, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_overflow", overflow, 0);
        enable = 0;
        ivalid = 1; tick(); tick(); ivalid = 0;
        check("dis_no_record", tif.t_valid, 0);
        enable = 1;
        ivalid = 1; tick(); ivalid = 0;
        check("dis_valid", tif.t_valid, 1);
        check("dis_order", tif.t_order, 2);

        // ---- randomized run against the model ----
        do_reset();
        model_clear();
        for (int c = 0; c < 3000; c++) begin
            int rbias;
            rbias = (c / 250) % 4;
            reset    = ($urandom_range(0, 599) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            ivalid   = $urandom_range(0, 1) == 1;
            trap     = $urandom_range(0, 5) == 0;
            pc       = $urandom;
            instr    = $urandom;
            rd_write = $urandom_range(0, 2) == 0;
            rd_waddr = 5'($urandom_range(0, 31));
            rd_wdata = $urandom;
            mvalid   = $urandom_range(0, 2) == 0;
            mwrite   = $urandom_range(0, 1) == 1;
            maddr    = $urandom;
            mdata    = $urandom;
            mstrb    = 4'($urandom_range(0, 15));
            tif.t_ready = ($urandom_range(0, 3) < rbias);
            model_step();
            tick();
            compare_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
